// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum-to-BCD conversion stage.
// Seven-segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package sum_bcd_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DIGITS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? 4'(din + 4'd3) : din;

endmodule

// File: rtl/sum_bcd_conv.sv
// Captures the adder result on done's rising edge and converts it to sign plus
// BCD digits by sequential shift-add-3. Optional SUM_BCD_CONV_SEG7_EN adds seg.
module sum_bcd_conv
  import sum_bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      sum,
  input  logic                  mode,
  input  logic                  done,
  input  logic                  error,
  input  logic                  ack,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  err_out,
  output logic                  valid,
  output logic                  busy,
  output logic                  overrun
`ifdef SUM_BCD_CONV_SEG7_EN
  ,
  output logic [7*DIGITS:0]     seg
`endif
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CAT_W = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic               done_q;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   dig_q, dig_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_pend_q, neg_pend_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               neg_d, err_d, valid_d, busy_d, overrun_d;

  logic               capture;
  logic [BCD_W-1:0]   adj;
  logic [CAT_W-1:0]   shifted;

  assign capture = done & ~done_q;

  // One correction cell per digit, applied before each shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (dig_q[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  assign shifted = CAT_W'({adj, mag_q} << 1);

`ifdef SUM_BCD_CONV_SEG7_EN
  logic [7*DIGITS:0] seg_d;

  function automatic logic [7*DIGITS:0] seg_word(input logic [BCD_W-1:0] d,
                                                 input logic n);
    logic [7*DIGITS:0] w;
    w = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      w[7*i +: 7] = seg_encode(d[4*i +: 4]);
    end
    w[7*DIGITS] = ~n;
    return w;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    dig_d      = dig_q;
    cnt_d      = cnt_q;
    neg_pend_d = neg_pend_q;
    bcd_d      = bcd;
    neg_d      = neg;
    err_d      = err_out;
    valid_d    = valid;
    busy_d     = busy;
    overrun_d  = overrun;
`ifdef SUM_BCD_CONV_SEG7_EN
    seg_d      = seg;
`endif

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          mag_d      = (mode && sum[WIDTH-1]) ? WIDTH'(~sum + 1'b1) : sum;
          dig_d      = '0;
          cnt_d      = '0;
          neg_pend_d = mode & sum[WIDTH-1];
          if (error) begin
            // Error results skip conversion and are presented as zero.
            state_d = ST_HOLD;
            bcd_d   = '0;
            neg_d   = 1'b0;
            err_d   = 1'b1;
            valid_d = 1'b1;
`ifdef SUM_BCD_CONV_SEG7_EN
            seg_d   = seg_word('0, 1'b0);
`endif
          end else begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end
        end
      end

      ST_SHIFT: begin
        dig_d = shifted[CAT_W-1:WIDTH];
        mag_d = shifted[WIDTH-1:0];
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (capture) overrun_d = 1'b1;
        // Final shift lands directly in the output register.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          bcd_d   = shifted[CAT_W-1:WIDTH];
          neg_d   = neg_pend_q;
          err_d   = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_HOLD;
`ifdef SUM_BCD_CONV_SEG7_EN
          seg_d   = seg_word(shifted[CAT_W-1:WIDTH], neg_pend_q);
`endif
        end
      end

      ST_HOLD: begin
        if (capture) overrun_d = 1'b1;
        if (ack) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      done_q     <= 1'b0;
      mag_q      <= '0;
      dig_q      <= '0;
      cnt_q      <= '0;
      neg_pend_q <= 1'b0;
      bcd        <= '0;
      neg        <= 1'b0;
      err_out    <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
`ifdef SUM_BCD_CONV_SEG7_EN
      seg        <= '1;
`endif
    end else begin
      state_q    <= state_d;
      done_q     <= done;
      mag_q      <= mag_d;
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      neg_pend_q <= neg_pend_d;
      bcd        <= bcd_d;
      neg        <= neg_d;
      err_out    <= err_d;
      valid      <= valid_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
`ifdef SUM_BCD_CONV_SEG7_EN
      seg        <= seg_d;
`endif
    end
  end

endmodule

// File: tb/tb_sum_bcd_conv.sv
// Self-checking bench for sum_bcd_conv (default build, WIDTH=8, DIGITS=3).
module tb_sum_bcd_conv;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    sum;
  logic                mode, done, error, ack;
  logic [4*DIGITS-1:0] bcd;
  logic                neg, err_out, valid, busy, overrun;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sum_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .sum     (sum),
    .mode    (mode),
    .done    (done),
    .error   (error),
    .ack     (ack),
    .bcd     (bcd),
    .neg     (neg),
    .err_out (err_out),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  typedef struct {
    logic [7:0]  sum;
    logic        mode;
    logic        err;
    logic [11:0] exp_bcd;
    logic        exp_neg;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Raise done with the given operands; returns just after the capture edge.
  task automatic start(input logic [7:0] s, input logic m, input logic e);
    @(negedge clk);
    sum = s; mode = m; error = e; done = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(output int lat, output int busy_n);
    lat    = 0;
    busy_n = busy ? 1 : 0;
    while (!valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_n++;
    end
  endtask

  task automatic ack_result(input string name, input logic [11:0] exp_bcd);
    @(negedge clk);
    ack = 1'b1; done = 1'b0;
    @(posedge clk); #1;
    check({name, " valid after ack"}, 32'(valid), 32'd0);
    check({name, " bcd retained"}, 32'(bcd), 32'(exp_bcd));
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    int lat, busy_n, rises;
    logic prev_busy;

    vecs[0]  = '{8'd255, 1'b0, 1'b0, 12'h255, 1'b0};
    vecs[1]  = '{8'hF6,  1'b1, 1'b0, 12'h010, 1'b1};
    vecs[2]  = '{8'h80,  1'b1, 1'b0, 12'h128, 1'b1};
    vecs[3]  = '{8'h00,  1'b0, 1'b0, 12'h000, 1'b0};
    vecs[4]  = '{8'hF6,  1'b0, 1'b0, 12'h246, 1'b0};
    vecs[5]  = '{8'h55,  1'b0, 1'b1, 12'h000, 1'b0};
    vecs[6]  = '{8'h7F,  1'b1, 1'b0, 12'h127, 1'b0};
    vecs[7]  = '{8'hFF,  1'b1, 1'b0, 12'h001, 1'b1};
    vecs[8]  = '{8'h80,  1'b1, 1'b1, 12'h000, 1'b0};
    vecs[9]  = '{8'd42,  1'b0, 1'b0, 12'h042, 1'b0};
    vecs[10] = '{8'd100, 1'b0, 1'b0, 12'h100, 1'b0};

    reset = 1'b0; sum = '0; mode = 1'b0; done = 1'b0; error = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset bcd", 32'(bcd), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset err_out", 32'(err_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Ack while idle must not produce a result.
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    check("idle ack valid", 32'(valid), 32'd0);
    @(negedge clk); ack = 1'b0;

    for (int i = 0; i < 11; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start(vecs[i].sum, vecs[i].mode, vecs[i].err);
      wait_valid(lat, busy_n);
      check({nm, " latency"}, 32'(lat), vecs[i].err ? 32'd0 : 32'd8);
      check({nm, " busy cycles"}, 32'(busy_n), vecs[i].err ? 32'd0 : 32'd8);
      check({nm, " valid"}, 32'(valid), 32'd1);
      check({nm, " bcd"}, 32'(bcd), 32'(vecs[i].exp_bcd));
      check({nm, " neg"}, 32'(neg), 32'(vecs[i].exp_neg));
      check({nm, " err_out"}, 32'(err_out), 32'(vecs[i].err));
      check({nm, " overrun"}, 32'(overrun), 32'd0);
      ack_result(nm, vecs[i].exp_bcd);
    end

    // Reset mid-conversion clears everything at once, then a clean conversion.
    start(8'd200, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0; done = 1'b0;
    #1;
    check("midreset bcd", 32'(bcd), 32'd0);
    check("midreset valid", 32'(valid), 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset neg", 32'(neg), 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    start(8'd42, 1'b0, 1'b0);
    wait_valid(lat, busy_n);
    check("postreset latency", 32'(lat), 32'd8);
    check("postreset bcd", 32'(bcd), 32'h042);
    ack_result("postreset", 12'h042);

    // done held high for 20 cycles yields a single conversion.
    start(8'd9, 1'b0, 1'b0);
    rises = busy ? 1 : 0;
    prev_busy = busy;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
    end
    check("held done conversions", 32'(rises), 32'd1);
    check("held done valid", 32'(valid), 32'd1);
    check("held done bcd", 32'(bcd), 32'h009);
    check("held done overrun", 32'(overrun), 32'd0);
    ack_result("held", 12'h009);

    // New done edge during SHIFT flags overrun and leaves the result intact.
    start(8'd77, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); done = 1'b0;
    @(negedge clk); done = 1'b1; sum = 8'd5;
    @(posedge clk); #1;
    check("overrun set", 32'(overrun), 32'd1);
    check("overrun busy", 32'(busy), 32'd1);
    wait_valid(lat, busy_n);
    check("overrun remaining latency", 32'(lat), 32'd4);
    check("overrun bcd", 32'(bcd), 32'h077);
    ack_result("overrun", 12'h077);
    check("overrun sticky", 32'(overrun), 32'd1);

    // Done edge coinciding with ack in HOLD is also not captured.
    start(8'd12, 1'b0, 1'b0);
    wait_valid(lat, busy_n);
    @(negedge clk); done = 1'b0;
    @(negedge clk); done = 1'b1; ack = 1'b1; sum = 8'd99;
    @(posedge clk); #1;
    check("ack+done valid", 32'(valid), 32'd0);
    @(negedge clk); ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ack+done no capture", 32'(busy), 32'd0);
    check("ack+done bcd", 32'(bcd), 32'h012);

    @(negedge clk); reset = 1'b0; done = 1'b0;
    #1;
    check("overrun cleared by reset", 32'(overrun), 32'd0);
    @(negedge clk); reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
